// File: rtl/mac_int8_seq.sv
// mac_int8_seq: sequencer for one external combinational int8 Booth multiplier.
// Takes a job (start + length) and streams operand pairs to the multiplier at
// one pair per cycle. Each product is registered and summed into a signed
// ACC_W-bit accumulator. The sum and a sticky overflow flag are returned on a
// valid/ready result port.
module mac_int8_seq #(
    parameter int ACC_W = 32,
    parameter int LEN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [8:0]       in_a,
    input  logic signed [7:0]       in_b,
    output logic signed [8:0]       mul_rs1,
    output logic signed [7:0]       mul_rs2,
    input  logic signed [16:0]      mul_res,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_acc,
    output logic                    out_ovf,
    output logic                    busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [LEN_W-1:0]        r_cnt;
    logic [LEN_W-1:0]        r_len;
    logic signed [8:0]       r_rs1;
    logic signed [7:0]       r_rs2;
    logic signed [16:0]      r_prod;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_ovf;
    // r_v1: operands sit at the multiplier. r_v2: the product register holds a product.
    // r_v3: an accumulate has just completed.
    logic                    r_v1;
    logic                    r_v2;
    logic                    r_v3;

    logic                    w_start_ok;
    logic                    w_hs;
    logic                    w_last;
    logic                    w_empty;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_add_ovf;

    assign w_start_ok = (r_state == S_IDLE) && start && !abort;
    assign w_hs       = in_valid && in_ready;
    assign w_last     = (r_cnt == r_len - LEN_W'(1));
    // DONE waits for r_v3 so that the result latency is fixed at 4 edges after the last accept.
    assign w_empty    = !r_v1 && !r_v2 && !r_v3;
    assign w_prod_ext = ACC_W'(r_prod);
    assign w_sum      = r_acc + w_prod_ext;
    // Signed overflow: the two addends have the same sign and the sum has the other sign.
    assign w_add_ovf  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                        (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

    // State register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; abort takes priority in every state
    // NOTE: default assignment first, so that no path through the case infers a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start_ok) w_next = (cfg_len != '0) ? S_RUN : S_DRAIN;
            S_RUN:   if (abort) w_next = S_IDLE;
                     else if (w_hs && w_last) w_next = S_DRAIN;
            S_DRAIN: if (abort) w_next = S_IDLE;
                     else if (w_empty) w_next = S_DONE;
            S_DONE:  if (abort || out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode from state; a pair offered in the abort cycle is refused
    always_comb begin
        in_ready  = (r_state == S_RUN) && (r_cnt < r_len) && !abort;
        out_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
        out_acc   = r_acc;
        out_ovf   = r_ovf;
        mul_rs1   = r_rs1;
        mul_rs2   = r_rs2;
    end

    // Job length, accept counter and multiplier operand registers (operands hold when idle)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len <= '0;
            r_cnt <= '0;
            r_rs1 <= '0;
            r_rs2 <= '0;
        end else begin
            if (w_start_ok) begin
                r_len <= cfg_len;
                r_cnt <= '0;
            end else if (w_hs) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
            if (w_hs) begin
                r_rs1 <= in_a;
                r_rs2 <= in_b;
            end
        end
    end

    // Pipeline valid flags and product register; abort empties the pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_prod <= '0;
        end else begin
            if (abort) begin
                r_v1 <= 1'b0;
                r_v2 <= 1'b0;
                r_v3 <= 1'b0;
            end else begin
                r_v1 <= w_hs;
                r_v2 <= r_v1;
                r_v3 <= r_v2;
            end
            if (r_v1) r_prod <= mul_res;
        end
    end

    // Accumulator with wrap-around and sticky overflow, both cleared on an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_start_ok) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (r_v2) begin
            r_acc <= w_sum;
            if (w_add_ovf) r_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mac_int8_seq.sv
// Testbench for mac_int8_seq. Two instances (ACC_W=32 and ACC_W=17) share the
// same stimulus. Each instance has its own behavioural multiplier. Results are
// compared against a plain-arithmetic dot-product model.
module tb_mac_int8_seq;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [15:0]       cfg_len;
    logic              in_valid;
    logic signed [8:0] in_a;
    logic signed [7:0] in_b;
    logic              out_ready;

    logic               d32_in_ready, d32_out_valid, d32_out_ovf, d32_busy;
    logic signed [31:0] d32_out_acc;
    logic signed [8:0]  d32_rs1;
    logic signed [7:0]  d32_rs2;
    logic signed [16:0] d32_res;

    logic               d17_in_ready, d17_out_valid, d17_out_ovf, d17_busy;
    logic signed [16:0] d17_out_acc;
    logic signed [8:0]  d17_rs1;
    logic signed [7:0]  d17_rs2;
    logic signed [16:0] d17_res;

    int n_cmp = 0;
    int n_err = 0;
    int job_a [32];
    int job_b [32];

    // Behavioural multipliers driven by the registered operands
    assign d32_res = 17'(d32_rs1) * 17'(d32_rs2);
    assign d17_res = 17'(d17_rs1) * 17'(d17_rs2);

    always #5 clk = ~clk;

    mac_int8_seq #(.ACC_W(32), .LEN_W(16)) dut32 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(d32_in_ready), .in_a(in_a), .in_b(in_b),
        .mul_rs1(d32_rs1), .mul_rs2(d32_rs2), .mul_res(d32_res),
        .out_valid(d32_out_valid), .out_ready(out_ready), .out_acc(d32_out_acc),
        .out_ovf(d32_out_ovf), .busy(d32_busy)
    );

    mac_int8_seq #(.ACC_W(17), .LEN_W(16)) dut17 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(d17_in_ready), .in_a(in_a), .in_b(in_b),
        .mul_rs1(d17_rs1), .mul_rs2(d17_rs2), .mul_res(d17_res),
        .out_valid(d17_out_valid), .out_ready(out_ready), .out_acc(d17_out_acc),
        .out_ovf(d17_out_ovf), .busy(d17_busy)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference dot product of job_a/job_b[0..n-1], wrapped to w bits, with overflow
    // defined as any partial sum leaving the signed w-bit range
    function automatic void model(input int n, input int w, output longint acc, output bit ovf);
        longint lim;
        longint s;
        lim = longint'(1) << (w - 1);
        acc = 0;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = acc + longint'(job_a[i]) * longint'(job_b[i]);
            if (s >= lim || s < -lim) ovf = 1'b1;
            s = s & ((lim << 1) - 1);
            if (s >= lim) s = s - (lim << 1);
            acc = s;
        end
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            job_a[i] = int'($urandom_range(0, 511)) - 256;
            job_b[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // One complete job: start, stream pairs, check latency, hold result, consume
    task automatic run_job(input int n, input bit gaps, input int hold, input bit poke, input string tag);
        longint e32, e17;
        bit     o32, o17;
        int     acc_cnt;
        int     guard;
        int     edges;
        bit     tog;
        model(n, 32, e32, o32);
        model(n, 17, e17, o17);
        check({tag, " idle before start"}, longint'(d32_busy), 0);
        start   = 1'b1;
        cfg_len = 16'(n);
        tick();
        start = 1'b0;
        check({tag, " busy after start"}, longint'(d32_busy), 1);
        acc_cnt = 0;
        guard   = 0;
        tog     = 1'b1;
        while (acc_cnt < n && guard < 1000) begin
            in_valid = gaps ? tog : 1'b1;
            tog      = ~tog;
            in_a     = 9'(job_a[acc_cnt]);
            in_b     = 8'(job_b[acc_cnt]);
            start    = poke;
            cfg_len  = 16'd9;
            #1;
            check({tag, " in_ready in RUN"}, longint'(d32_in_ready), 1);
            if (in_valid) acc_cnt++;
            tick();
            guard++;
        end
        start    = 1'b0;
        in_valid = 1'b1;
        #1;
        check({tag, " in_ready after last accept"}, longint'(d32_in_ready), 0);
        edges = 0;
        while (!d32_out_valid && edges < 20) begin
            tick();
            edges++;
        end
        in_valid = 1'b0;
        check({tag, " result latency"}, longint'(edges), (n > 0) ? 4 : 1);
        if (n > 0) check({tag, " mul_rs1 holds last a"}, longint'(d32_rs1), longint'(job_a[n-1]));
        for (int h = 0; h < hold; h++) begin
            start   = poke;
            cfg_len = 16'd1;
            check({tag, " held out_valid"}, longint'(d32_out_valid), 1);
            check({tag, " held out_acc"}, longint'(d32_out_acc), e32);
            tick();
        end
        start = 1'b0;
        check({tag, " out_acc32"}, longint'(d32_out_acc), e32);
        check({tag, " out_ovf32"}, longint'(d32_out_ovf), longint'(o32));
        check({tag, " out_valid17"}, longint'(d17_out_valid), 1);
        check({tag, " out_acc17"}, longint'(d17_out_acc), e17);
        check({tag, " out_ovf17"}, longint'(d17_out_ovf), longint'(o17));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " idle after consume"}, longint'(d32_busy), 0);
        check({tag, " out_valid drops"}, longint'(d32_out_valid), 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; cfg_len = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset busy", longint'(d32_busy), 0);
        check("reset out_valid", longint'(d32_out_valid), 0);
        check("reset in_ready", longint'(d32_in_ready), 0);
        check("reset out_acc", longint'(d32_out_acc), 0);
        check("reset out_ovf", longint'(d32_out_ovf), 0);
        check("reset mul_rs1", longint'(d32_rs1), 0);
        check("reset mul_rs2", longint'(d32_rs2), 0);
        check("reset out_acc17", longint'(d17_out_acc), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Small directed dot product (-698)
        job_a[0] = 3;   job_b[0] = 4;
        job_a[1] = -2;  job_b[1] = 5;
        job_a[2] = 100; job_b[2] = -7;
        run_job(3, 1'b0, 0, 1'b0, "basic3");

        // 17-bit product extremes
        job_a[0] = -256; job_b[0] = -128;
        run_job(1, 1'b0, 1, 1'b0, "ext_pos");
        job_a[0] = 255;  job_b[0] = -128;
        run_job(1, 1'b0, 0, 1'b0, "ext_neg");

        // Wrap and overflow on the 17-bit instance, then ovf cleared by the next job
        job_a[0] = -256; job_b[0] = -128;
        job_a[1] = -256; job_b[1] = -128;
        run_job(2, 1'b0, 0, 1'b0, "wrap17");
        job_a[0] = 1; job_b[0] = 1;
        run_job(1, 1'b0, 0, 1'b0, "after_wrap");

        // Input gaps and result backpressure
        for (int i = 0; i < 4; i++) begin job_a[i] = 1; job_b[i] = 1; end
        run_job(4, 1'b1, 5, 1'b0, "backpressure");

        // Zero-length job, and start pulses while busy
        run_job(0, 1'b0, 2, 1'b0, "len0");
        job_a[0] = 10; job_b[0] = -3;
        job_a[1] = -7; job_b[1] = 9;
        run_job(2, 1'b0, 3, 1'b1, "start_ignored");

        // start and abort in the same cycle
        start = 1'b1; abort = 1'b1; cfg_len = 16'd3;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start+abort busy", longint'(d32_busy), 0);

        // Abort after 2 of 5 pairs
        fill_random(5);
        start = 1'b1; cfg_len = 16'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_a = 9'(job_a[i]); in_b = 8'(job_b[i]);
            tick();
        end
        abort = 1'b1;
        #1;
        check("abort refuses pair", longint'(d32_in_ready), 0);
        tick();
        abort = 1'b0; in_valid = 1'b0;
        check("abort busy", longint'(d32_busy), 0);
        check("abort out_valid", longint'(d32_out_valid), 0);
        tick();
        check("abort stays idle", longint'(d32_busy), 0);

        // Reset in the middle of a job
        start = 1'b1; cfg_len = 16'd3;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 9'sd50; in_b = 8'sd2;
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid-run reset busy", longint'(d32_busy), 0);
        check("mid-run reset out_valid", longint'(d32_out_valid), 0);
        check("mid-run reset mul_rs1", longint'(d32_rs1), 0);
        tick();
        rst = 1'b0;
        tick();

        job_a[0] = 7; job_b[0] = 3;
        run_job(1, 1'b0, 0, 1'b0, "after_reset");

        // Randomised jobs
        for (int r = 0; r < 8; r++) begin
            int n;
            n = int'($urandom_range(1, 12));
            fill_random(n);
            run_job(n, r[0], int'($urandom_range(0, 4)), 1'b0, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
